// File: rtl/proc_controller_p_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : proc_controller_p_if                                            |
// | Brief    : Bus bundle between the multicycle controller and its datapath.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface proc_controller_p_if #(
    parameter int IW    = 16,
    parameter int PC_W  = 7,
    parameter int RF_AW = 4,
    parameter int D_AW  = 8,
    parameter int CNT_W = 16
);
    logic              IM_req;
    logic [PC_W-1:0]   IM_addr;
    logic              IM_valid;
    logic [IW-1:0]     IM_rdata;
    logic              Ra_zero;
    logic [D_AW-1:0]   D_addr;
    logic              D_wr;
    logic [1:0]        RF_s;
    logic [D_AW-1:0]   Const_out;
    logic [RF_AW-1:0]  RF_W_addr;
    logic              RF_W_en;
    logic [RF_AW-1:0]  RF_Ra_addr;
    logic [RF_AW-1:0]  RF_Rb_addr;
    logic [2:0]        ALU_s0;
    logic [PC_W-1:0]   PC_out;
    logic [IW-1:0]     IR_out;
    logic [3:0]        State;
    logic [3:0]        NextState;
    logic              Halted;
    logic              Illegal;
    logic [CNT_W-1:0]  Retired;

    modport master (
        output IM_req, IM_addr, D_addr, D_wr, RF_s, Const_out, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_s0, PC_out, IR_out, State, NextState,
               Halted, Illegal, Retired,
        input  IM_valid, IM_rdata, Ra_zero
    );

    modport slave (
        input  IM_req, IM_addr, D_addr, D_wr, RF_s, Const_out, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_s0, PC_out, IR_out, State, NextState,
               Halted, Illegal, Retired,
        output IM_valid, IM_rdata, Ra_zero
    );
endinterface
`default_nettype wire

// File: rtl/proc_controller_p.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : proc_controller_p                                               |
// | Brief    : Multicycle processor control FSM with wait-state tolerant fetch, |
// |            LOADC/JPZ support, illegal-opcode flag and retired counter.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module proc_controller_p #(
    parameter int IW    = 16,
    parameter int PC_W  = 7,
    parameter int RF_AW = 4,
    parameter int D_AW  = 8,
    parameter int CNT_W = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    proc_controller_p_if.master  bus
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD_A = 4'd3,
        S_LOAD_B = 4'd4,
        S_STORE  = 4'd5,
        S_ADD    = 4'd6,
        S_SUB    = 4'd7,
        S_HALT   = 4'd8,
        S_LOADC  = 4'd9,
        S_JPZ    = 4'd10
    } state_t;

    localparam logic [3:0] c_OP_STORE = 4'd1;
    localparam logic [3:0] c_OP_LOAD  = 4'd2;
    localparam logic [3:0] c_OP_ADD   = 4'd3;
    localparam logic [3:0] c_OP_SUB   = 4'd4;
    localparam logic [3:0] c_OP_HALT  = 4'd5;
    localparam logic [3:0] c_OP_LOADC = 4'd6;
    localparam logic [3:0] c_OP_JPZ   = 4'd7;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [IW-1:0]      ir_q, ir_d;
    logic [CNT_W-1:0]   retired_q, retired_d;

    logic [3:0]         w_opcode;
    logic [RF_AW-1:0]   w_fld_w;
    logic [RF_AW-1:0]   w_fld_rb;
    logic [RF_AW-1:0]   w_fld_ra_alu;
    logic [D_AW-1:0]    w_fld_d_ld;
    logic [RF_AW-1:0]   w_fld_ra_st;
    logic [D_AW-1:0]    w_fld_d_st;
    logic [PC_W-1:0]    w_jump_target;

    // Two instruction layouts overlap: ALU/LOAD style (W low) and STORE/JPZ style (D low).
    assign w_opcode      = ir_q[IW-1:IW-4];
    assign w_fld_w       = ir_q[RF_AW-1:0];
    assign w_fld_rb      = ir_q[2*RF_AW-1:RF_AW];
    assign w_fld_ra_alu  = ir_q[3*RF_AW-1:2*RF_AW];
    assign w_fld_d_ld    = ir_q[RF_AW+D_AW-1:RF_AW];
    assign w_fld_ra_st   = ir_q[D_AW+RF_AW-1:D_AW];
    assign w_fld_d_st    = ir_q[D_AW-1:0];
    assign w_jump_target = ir_q[PC_W-1:0];

    assign bus.IM_addr   = pc_q;
    assign bus.PC_out    = pc_q;
    assign bus.IR_out    = ir_q;
    assign bus.State     = state_q;
    assign bus.NextState = state_d;
    assign bus.Retired   = retired_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_INIT;
            pc_q      <= '0;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        ir_d           = ir_q;
        retired_d      = retired_q;
        bus.IM_req     = 1'b0;
        bus.D_addr     = '0;
        bus.D_wr       = 1'b0;
        bus.RF_s       = 2'd0;
        bus.Const_out  = '0;
        bus.RF_W_addr  = '0;
        bus.RF_W_en    = 1'b0;
        bus.RF_Ra_addr = '0;
        bus.RF_Rb_addr = '0;
        bus.ALU_s0     = 3'd0;
        bus.Halted     = 1'b0;
        bus.Illegal    = 1'b0;

        case (state_q)
            S_INIT: state_d = S_FETCH;
            S_FETCH: begin
                bus.IM_req = 1'b1;
                if (bus.IM_valid) begin
                    ir_d    = bus.IM_rdata;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                bus.Illegal = w_opcode[3];
                case (w_opcode)
                    c_OP_STORE: state_d = S_STORE;
                    c_OP_LOAD:  state_d = S_LOAD_A;
                    c_OP_ADD:   state_d = S_ADD;
                    c_OP_SUB:   state_d = S_SUB;
                    c_OP_HALT:  state_d = S_HALT;
                    c_OP_LOADC: state_d = S_LOADC;
                    c_OP_JPZ:   state_d = S_JPZ;
                    default: begin
                        // NOOP and illegal opcodes retire straight from decode
                        state_d   = S_FETCH;
                        retired_d = retired_q + CNT_W'(1);
                    end
                endcase
            end
            S_LOAD_A: begin
                bus.D_addr    = w_fld_d_ld;
                bus.RF_s      = 2'd1;
                bus.RF_W_addr = w_fld_w;
                state_d       = S_LOAD_B;
            end
            S_LOAD_B: begin
                bus.D_addr    = w_fld_d_ld;
                bus.RF_s      = 2'd1;
                bus.RF_W_addr = w_fld_w;
                bus.RF_W_en   = 1'b1;
                state_d       = S_FETCH;
                retired_d     = retired_q + CNT_W'(1);
            end
            S_STORE: begin
                bus.RF_Ra_addr = w_fld_ra_st;
                bus.D_addr     = w_fld_d_st;
                bus.D_wr       = 1'b1;
                state_d        = S_FETCH;
                retired_d      = retired_q + CNT_W'(1);
            end
            S_ADD, S_SUB: begin
                bus.RF_Ra_addr = w_fld_ra_alu;
                bus.RF_Rb_addr = w_fld_rb;
                bus.RF_W_addr  = w_fld_w;
                bus.ALU_s0     = (state_q == S_ADD) ? 3'd1 : 3'd2;
                bus.RF_W_en    = 1'b1;
                state_d        = S_FETCH;
                retired_d      = retired_q + CNT_W'(1);
            end
            S_LOADC: begin
                bus.RF_s      = 2'd2;
                bus.Const_out = w_fld_d_ld;
                bus.RF_W_addr = w_fld_w;
                bus.RF_W_en   = 1'b1;
                state_d       = S_FETCH;
                retired_d     = retired_q + CNT_W'(1);
            end
            S_JPZ: begin
                bus.RF_Ra_addr = w_fld_ra_st;
                if (bus.Ra_zero) begin
                    pc_d = w_jump_target;
                end
                state_d   = S_FETCH;
                retired_d = retired_q + CNT_W'(1);
            end
            S_HALT: bus.Halted = 1'b1;
            default: state_d = S_INIT;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_proc_controller_p.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_proc_controller_p                                            |
// | Brief    : Scoreboard bench: ISA-level model predicts fetch/write events,  |
// |            a datapath model and monitor compare them against the DUT.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_proc_controller_p;
    localparam int IW = 16, PC_W = 7, RF_AW = 4, D_AW = 8, CNT_W = 16;
    localparam logic [1:0] K_FETCH = 2'd0, K_DWR = 2'd1, K_RFW = 2'd2, K_ILL = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] a;
        logic [15:0] b;
    } ev_t;

    logic Clk = 1'b0;
    logic Reset = 1'b0;

    proc_controller_p_if #(.IW(IW), .PC_W(PC_W), .RF_AW(RF_AW), .D_AW(D_AW), .CNT_W(CNT_W)) bus ();
    proc_controller_p #(.IW(IW), .PC_W(PC_W), .RF_AW(RF_AW), .D_AW(D_AW), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .bus(bus)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;
    ev_t exp_q[$];
    logic [15:0] trace [0:511];
    int trace_len = 0;
    int fetch_idx = 0;
    int wait_cnt = 0;
    int wait_mode = 0;
    int seed = 0;
    logic [15:0] rf [0:15];
    logic [15:0] dm [0:255];

    function automatic logic [15:0] init_rf(input int s, input int i);
        logic [31:0] h;
        if (s == 0) return 16'(i * 257);
        h = (32'(s) * 32'h9E3779B1) ^ (32'(i) * 32'h85EBCA77);
        h = (h ^ (h >> 13)) * 32'hC2B2AE35;
        return (h[2:0] < 3'd2) ? 16'h0 : h[15:0];
    endfunction

    function automatic logic [15:0] init_dm(input int s, input int a);
        logic [31:0] h;
        if (s == 0) return 16'(a * 3 + 1);
        h = (32'(s) * 32'h7FEB352D) ^ (32'(a) * 32'h846CA68B);
        h = (h ^ (h >> 15)) * 32'h27D4EB2F;
        return h[15:0];
    endfunction

    function automatic int pick_wait();
        if (wait_mode == 0) return 0;
        if (wait_mode == 1) return 3;
        return int'($urandom_range(0, 3));
    endfunction

    function automatic logic [15:0] wb_value();
        case (bus.RF_s)
            2'd0: case (bus.ALU_s0)
                      3'd0: return rf[bus.RF_Ra_addr];
                      3'd1: return rf[bus.RF_Ra_addr] + rf[bus.RF_Rb_addr];
                      3'd2: return rf[bus.RF_Ra_addr] - rf[bus.RF_Rb_addr];
                      default: return 16'hDEAD;
                  endcase
            2'd1: return dm[bus.D_addr];
            2'd2: return {8'h00, bus.Const_out};
            default: return 16'hBEEF;
        endcase
    endfunction

    function automatic ev_t mk(input logic [1:0] k, input logic [15:0] a, input logic [15:0] b);
        ev_t e;
        e.kind = k; e.a = a; e.b = b;
        return e;
    endfunction

    // Instruction memory: serves the trace in fetch order, with wait states
    assign bus.IM_valid = bus.IM_req && (wait_cnt == 0);
    assign bus.IM_rdata = (fetch_idx < trace_len) ? trace[fetch_idx] : 16'h5000;
    assign bus.Ra_zero  = (rf[bus.RF_Ra_addr] == 16'h0);

    initial begin : responder
        logic acc, req;
        forever begin
            @(negedge Clk);
            acc = bus.IM_req && bus.IM_valid;
            req = bus.IM_req;
            @(posedge Clk);
            #1;
            if (Reset) begin
                fetch_idx = 0;
                wait_cnt  = pick_wait();
            end else if (acc) begin
                fetch_idx = fetch_idx + 1;
                wait_cnt  = pick_wait();
            end else if (req && wait_cnt > 0) begin
                wait_cnt = wait_cnt - 1;
            end
        end
    end

    initial begin : datapath
        logic do_d, do_w;
        logic [7:0] d_a;
        logic [3:0] w_a;
        logic [15:0] d_v, w_v;
        forever begin
            @(negedge Clk);
            do_d = 1'b0; do_w = 1'b0; d_a = '0; w_a = '0; d_v = '0; w_v = '0;
            if (Reset) begin
                for (int i = 0; i < 16; i++) rf[i] = init_rf(seed, i);
                for (int a = 0; a < 256; a++) dm[a] = init_dm(seed, a);
            end else begin
                do_d = bus.D_wr;    d_a = bus.D_addr;    d_v = rf[bus.RF_Ra_addr];
                do_w = bus.RF_W_en; w_a = bus.RF_W_addr; w_v = wb_value();
            end
            @(posedge Clk);
            #1;
            if (!Reset) begin
                if (do_d) dm[d_a] = d_v;
                if (do_w) rf[w_a] = w_v;
            end
        end
    end

    task automatic sb_check(input logic [1:0] k, input logic [15:0] a, input logic [15:0] b, input string name);
        ev_t e;
        checks = checks + 1;
        if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL %s: got kind=%0d a=%h b=%h, required no event", name, k, a, b);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.a != a || e.b != b) begin
                errors = errors + 1;
                $display("FAIL %s: got kind=%0d a=%h b=%h, required kind=%0d a=%h b=%h",
                         name, k, a, b, e.kind, e.a, e.b);
            end
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge Clk);
            if (!Reset) begin
                if (bus.IM_req && bus.IM_valid) sb_check(K_FETCH, 16'(bus.IM_addr), 16'h0, "fetch");
                if (bus.D_wr) sb_check(K_DWR, 16'(bus.D_addr), rf[bus.RF_Ra_addr], "dmem_write");
                if (bus.RF_W_en) sb_check(K_RFW, 16'(bus.RF_W_addr), wb_value(), "rf_write");
                if (bus.Illegal) sb_check(K_ILL, 16'h0, 16'h0, "illegal");
                if (bus.D_wr) begin
                    checks = checks + 1;
                    if (bus.RF_W_en) begin
                        errors = errors + 1;
                        $display("FAIL write_exclusive: got D_wr=1 RF_W_en=1, required only one");
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks = checks + 1;
        if (got !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // Architectural model: executes the instruction stream one instruction at a time
    task automatic model_run(output int ret);
        logic [15:0] mrf [0:15];
        logic [15:0] mdm [0:255];
        logic [15:0] ir, v;
        logic [3:0]  op;
        int pc;
        ret = 0;
        pc  = 0;
        for (int i = 0; i < 16; i++) mrf[i] = init_rf(seed, i);
        for (int a = 0; a < 256; a++) mdm[a] = init_dm(seed, a);
        for (int k = 0; k < trace_len; k++) begin
            ir = trace[k];
            op = ir[15:12];
            exp_q.push_back(mk(K_FETCH, 16'(pc), 16'h0));
            pc = (pc + 1) % 128;
            if (op == 4'd5) break;
            case (op)
                4'd1: begin
                    exp_q.push_back(mk(K_DWR, {8'h0, ir[7:0]}, mrf[ir[11:8]]));
                    mdm[ir[7:0]] = mrf[ir[11:8]];
                end
                4'd2: begin
                    v = mdm[ir[11:4]];
                    exp_q.push_back(mk(K_RFW, {12'h0, ir[3:0]}, v));
                    mrf[ir[3:0]] = v;
                end
                4'd3, 4'd4: begin
                    v = (op == 4'd3) ? mrf[ir[11:8]] + mrf[ir[7:4]] : mrf[ir[11:8]] - mrf[ir[7:4]];
                    exp_q.push_back(mk(K_RFW, {12'h0, ir[3:0]}, v));
                    mrf[ir[3:0]] = v;
                end
                4'd6: begin
                    v = {8'h0, ir[11:4]};
                    exp_q.push_back(mk(K_RFW, {12'h0, ir[3:0]}, v));
                    mrf[ir[3:0]] = v;
                end
                4'd7: if (mrf[ir[11:8]] == 16'h0) pc = int'(ir[6:0]);
                4'd0: ;
                default: exp_q.push_back(mk(K_ILL, 16'h0, 16'h0));
            endcase
            ret = ret + 1;
        end
    endtask

    task automatic run_prog(input int s, input int wm, input int exp_cycles, input string name);
        int exp_ret, cyc;
        Reset = 1'b1;
        seed = s;
        wait_mode = wm;
        exp_q.delete();
        model_run(exp_ret);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        cyc = 0;
        while (!bus.Halted && cyc < 4000) begin
            @(posedge Clk);
            #1;
            cyc = cyc + 1;
        end
        chk({name, "_halted"}, 32'(bus.Halted), 32'd1);
        chk({name, "_retired"}, 32'(bus.Retired), 32'(exp_ret));
        chk({name, "_pending_events"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_halt_no_fetch"}, 32'(bus.IM_req), 32'd0);
        if (exp_cycles >= 0) chk({name, "_cycles"}, 32'(cyc), 32'(exp_cycles));
    endtask

    task automatic load4(input logic [15:0] a, b, c, d);
        trace[0] = a; trace[1] = b; trace[2] = c; trace[3] = d;
        trace_len = 4;
    endtask

    initial begin : main
        int r, cyc;
        logic [3:0] op;
        #1 Reset = 1'b1;

        load4(16'h2105, 16'h2206, 16'h3012, 16'h1203);
        trace[4] = 16'h5000; trace_len = 5;
        run_prog(0, 0, 17, "prog_nowait");
        chk("prog_nowait_dmem3", 32'(dm[3]), 32'(init_rf(0, 0) + init_rf(0, 1)));
        run_prog(0, 1, 32, "prog_wait3");

        load4(16'h6AB1, 16'h7110, 16'h7010, 16'h5000);
        run_prog(0, 0, 12, "loadc_jpz");
        chk("loadc_r1", 32'(rf[1]), 32'h00AB);

        load4(16'h707F, 16'hF123, 16'h0000, 16'h5000);
        run_prog(0, 0, 10, "wrap_illegal");
        chk("wrap_pc", 32'(bus.PC_out), 32'h02);

        // Reset mid-LOAD_A after one retired NOOP
        load4(16'h0000, 16'h2105, 16'h5000, 16'h5000);
        trace_len = 3;
        Reset = 1'b1; seed = 0; wait_mode = 0; exp_q.delete();
        model_run(r);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        cyc = 0;
        while (bus.State != 4'd3 && cyc < 50) begin
            @(negedge Clk);
            cyc = cyc + 1;
        end
        chk("rst_reached_load_a", 32'(bus.State), 32'd3);
        chk("rst_retired_before", 32'(bus.Retired), 32'd1);
        #1 Reset = 1'b1;
        #1;
        chk("rst_state", 32'(bus.State), 32'd0);
        chk("rst_rf_w_en", 32'(bus.RF_W_en), 32'd0);
        chk("rst_pc", 32'(bus.PC_out), 32'd0);
        chk("rst_retired", 32'(bus.Retired), 32'd0);
        chk("rst_ir", 32'(bus.IR_out), 32'd0);
        chk("rst_next_state", 32'(bus.NextState), 32'd1);
        exp_q.delete();
        repeat (2) @(posedge Clk);

        for (int t = 1; t <= 6; t++) begin
            for (int i = 0; i < 40; i++) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'd5) op = 4'd0;
                trace[i] = {op, 12'($urandom)};
            end
            trace[40] = 16'h5000;
            trace_len = 41;
            run_prog(t * 7 + 3, 2, -1, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
